// File: rtl/bmp_stream_writer.sv
//============================================================================
// Module   : bmp_stream_writer
// Brief    : Serialises a 24-bit BMP file (54-byte header, then BGR pixel
//            bytes) from a stream of two-pixel beats, with a valid/ready
//            byte output.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module bmp_stream_writer #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       VSYNC,
    input  logic       HSYNC,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic [7:0] BYTE_OUT,
    output logic       BYTE_VALID,
    input  logic       BYTE_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVERFLOW
);

    localparam int                 c_AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_PIX_TOTAL = WIDTH * HEIGHT * 3;
    localparam int                 c_PIX_W     = ($clog2(c_PIX_TOTAL + 1) > 24) ? $clog2(c_PIX_TOTAL + 1) : 24;
    localparam logic [c_PIX_W-1:0] c_PIX_LAST  = c_PIX_W'(c_PIX_TOTAL - 1);
    localparam logic [31:0]        c_IMG_SIZE  = 32'(c_PIX_TOTAL);
    localparam logic [31:0]        c_FILE_SIZE = 32'(54 + c_PIX_TOTAL);
    localparam logic [5:0]         c_HDR_LAST  = 6'd53;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_HEADER = 2'd1;
    localparam logic [1:0] c_PIXELS = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_vsync_q;
    logic               w_vsync_rise;
    logic [5:0]         r_hdr_idx;
    logic [c_PIX_W-1:0] r_pix_cnt;
    logic [47:0]        r_mem [FIFO_DEPTH];
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_xfer;
    logic               w_out_load;
    logic               w_pix_last;
    logic [47:0]        r_ser_data;
    logic [2:0]         r_ser_cnt;
    logic [7:0]         w_ser_byte;
    logic [7:0]         r_byte_out;
    logic               r_byte_valid;
    logic               r_overflow;

    // Header fields are 4-byte aligned from byte 2; bytes 26..29 pack planes=1, bpp=24.
    function automatic logic [7:0] f_hdr_byte(input logic [5:0] idx);
        logic [5:0]  v_off;
        logic [31:0] v_word;
        v_off = idx - 6'd2;
        case (v_off[5:2])
            4'd0:    v_word = c_FILE_SIZE;
            4'd2:    v_word = 32'd54;
            4'd3:    v_word = 32'd40;
            4'd4:    v_word = 32'(WIDTH);
            4'd5:    v_word = 32'(HEIGHT);
            4'd6:    v_word = 32'h0018_0001;
            4'd8:    v_word = c_IMG_SIZE;
            default: v_word = 32'd0;
        endcase
        if (idx == 6'd0)
            f_hdr_byte = 8'h42;
        else if (idx == 6'd1)
            f_hdr_byte = 8'h4D;
        else
            f_hdr_byte = v_word[{v_off[1:0], 3'b000} +: 8];
    endfunction

    assign w_vsync_rise = VSYNC & ~r_vsync_q;
    assign w_xfer       = r_byte_valid & BYTE_READY;
    assign w_out_load   = ~r_byte_valid | BYTE_READY;
    assign w_pix_last   = (r_state == c_PIXELS) && w_xfer && (r_pix_cnt == c_PIX_LAST);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) && (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_pop        = (r_state == c_PIXELS) && !w_empty &&
                          ((r_ser_cnt == 3'd0) || ((r_ser_cnt == 3'd1) && w_out_load));
    assign w_push_req   = HSYNC && ((r_state == c_HEADER) || (r_state == c_PIXELS));
    assign w_push       = w_push_req && (!w_full || w_pop);

    // Remaining-byte count selects B0,G0,R0,B1,G1,R1 from the {R0,G0,B0,R1,G1,B1} beat.
    always_comb begin
        w_ser_byte = 8'd0;
        case (r_ser_cnt)
            3'd6:    w_ser_byte = r_ser_data[31:24];
            3'd5:    w_ser_byte = r_ser_data[39:32];
            3'd4:    w_ser_byte = r_ser_data[47:40];
            3'd3:    w_ser_byte = r_ser_data[7:0];
            3'd2:    w_ser_byte = r_ser_data[15:8];
            3'd1:    w_ser_byte = r_ser_data[23:16];
            default: w_ser_byte = 8'd0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_vsync_rise) w_next = c_HEADER;
            c_HEADER: if (w_xfer && (r_hdr_idx == c_HDR_LAST)) w_next = c_PIXELS;
            c_PIXELS: if (w_pix_last) w_next = c_FINISH;
            default:  w_next = c_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (r_state != c_IDLE);
        DONE = w_pix_last;
    end

    always_ff @(posedge HCLK) begin
        if (w_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_vsync_q    <= 1'b0;
            r_hdr_idx    <= 6'd0;
            r_pix_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ser_data   <= 48'd0;
            r_ser_cnt    <= 3'd0;
            r_byte_out   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_vsync_q <= VSYNC;
            if (w_push_req && w_full && !w_pop)
                r_overflow <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (r_state == c_FINISH)
                r_rd_ptr <= r_wr_ptr;
            else if (w_pop)
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);

            case (r_state)
                c_IDLE: begin
                    if (w_vsync_rise) begin
                        r_byte_out   <= f_hdr_byte(6'd0);
                        r_byte_valid <= 1'b1;
                        r_hdr_idx    <= 6'd0;
                        r_pix_cnt    <= '0;
                        r_ser_cnt    <= 3'd0;
                    end
                end
                c_HEADER: begin
                    if (w_xfer) begin
                        if (r_hdr_idx == c_HDR_LAST) begin
                            r_byte_valid <= 1'b0;
                        end else begin
                            r_hdr_idx  <= r_hdr_idx + 6'd1;
                            r_byte_out <= f_hdr_byte(r_hdr_idx + 6'd1);
                        end
                    end
                end
                c_PIXELS: begin
                    if (w_xfer)
                        r_pix_cnt <= r_pix_cnt + c_PIX_W'(1);
                    if (w_out_load) begin
                        if (r_ser_cnt != 3'd0) begin
                            r_byte_out   <= w_ser_byte;
                            r_byte_valid <= 1'b1;
                            r_ser_cnt    <= r_ser_cnt - 3'd1;
                        end else begin
                            r_byte_valid <= 1'b0;
                        end
                    end
                    // A pop refills the serializer after its last byte has moved out.
                    if (w_pop) begin
                        r_ser_data <= r_mem[r_rd_ptr[c_AW-1:0]];
                        r_ser_cnt  <= 3'd6;
                    end
                end
                default: begin
                    r_byte_valid <= 1'b0;
                    r_ser_cnt    <= 3'd0;
                end
            endcase
        end
    end

    assign BYTE_OUT   = r_byte_out;
    assign BYTE_VALID = r_byte_valid;
    assign OVERFLOW   = r_overflow;

endmodule

`default_nettype wire

// File: doc/bmp_stream_writer.md
BMP_STREAM_WRITER -- requirements
Module: bmp_stream_writer

Parameters
REQ-001 SHALL have parameter WIDTH, default 768, image width in pixels; must be even, and WIDTH*3 must be a multiple of 4 (no row padding).
REQ-002 SHALL have parameter HEIGHT, default 512, image height in rows.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, number of 48-bit two-pixel beat entries; must be a power of 2.

Interface
REQ-004 HCLK  in  1  single clock; all logic on rising edge.
REQ-005 HRESET  in  1  reset, synchronous, active-high.
REQ-006 VSYNC  in  1  frame-start indicator from the upstream pixel reader.
REQ-007 HSYNC  in  1  beat qualifier; high = DATA_* carries a valid two-pixel beat this cycle.
REQ-008 DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel of the beat.
REQ-009 DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel of the beat.
REQ-010 BYTE_OUT  out  8  serialized BMP byte.
REQ-011 BYTE_VALID  out  1  BYTE_OUT holds a valid byte.
REQ-012 BYTE_READY  in  1  sink accepts the byte; a transfer occurs when BYTE_VALID and BYTE_READY are both high.
REQ-013 BUSY  out  1  high in any state other than IDLE.
REQ-014 DONE  out  1  one-cycle pulse when the last pixel byte of a frame transfers.
REQ-015 OVERFLOW  out  1  sticky flag, set when a beat is dropped.

Function
REQ-016 SHALL implement states IDLE, HEADER, PIXELS and FINISH.
REQ-017 SHALL register VSYNC each cycle; a rising edge (VSYNC=1, previous sample=0) seen in IDLE SHALL move to HEADER on the next edge; VSYNC edges outside IDLE SHALL be ignored.
REQ-018 In HEADER, SHALL emit 54 little-endian header bytes in this order:
- 0x42 0x4D
- file size = 54+WIDTH*HEIGHT*3 (4 bytes)
- 0 (4 bytes)
- 54 (4 bytes)
- 40 (4 bytes)
- WIDTH (4 bytes)
- HEIGHT (4 bytes)
- 1 (2 bytes)
- 24 (2 bytes)
- 0 (4 bytes)
- WIDTH*HEIGHT*3 (4 bytes)
- 0 (16 bytes)
REQ-019 After header byte 53 transfers, SHALL enter PIXELS.
REQ-020 SHALL push a beat {R0,G0,B0,R1,G1,B1} into the FIFO on every cycle with HSYNC=1 while in HEADER or PIXELS; HSYNC in IDLE or FINISH SHALL be ignored.
REQ-021 If the FIFO is full and no pop occurs in the same cycle, the beat SHALL be dropped and OVERFLOW set; a simultaneous push and pop on a full FIFO SHALL accept the push.
REQ-022 In PIXELS, SHALL pop one beat into a 6-byte serializer when the serializer is empty or its last byte is transferring.
REQ-023 Serializer byte order SHALL be B0, G0, R0, B1, G1, R1 (BMP BGR order).
REQ-024 BYTE_OUT SHALL be driven from a register.
REQ-025 While BYTE_VALID=1 and BYTE_READY=0, BYTE_OUT and BYTE_VALID SHALL hold stable.
REQ-026 BYTE_VALID SHALL drop only after a transfer with no byte pending.
REQ-027 Latency: with the FIFO and serializer empty in PIXELS, a beat captured at edge t SHALL present B0 on BYTE_OUT with BYTE_VALID=1 after edge t+2.
REQ-028 The first header byte SHALL appear with BYTE_VALID=1 after the edge that enters HEADER.
REQ-029 SHALL count transferred pixel bytes in a counter at least 24 bits wide. When the count reaches WIDTH*HEIGHT*3, SHALL pulse DONE in that transfer cycle and enter FINISH.
REQ-030 FINISH SHALL flush (discard) the FIFO contents and return to IDLE on the next edge.
REQ-031 Header and pixel counters SHALL clear on entry to HEADER, so back-to-back frames are independent.
REQ-032 OVERFLOW SHALL clear only on reset.

Reset
REQ-033 While HRESET=1 at a rising edge, SHALL enter IDLE and empty the FIFO.
REQ-034 Reset SHALL clear all counters and the VSYNC sample, and set BYTE_OUT=0, BYTE_VALID=0, BUSY=0, DONE=0, OVERFLOW=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no further bytes; a new frame requires a new VSYNC rising edge.

Verification
REQ-036 WIDTH=4, HEIGHT=2, BYTE_READY=1, VSYNC pulse -> bytes 0-5 are 42 4D 4E 00 00 00; bytes 18/22 are 04/02; bytes 34-37 are 18 00 00 00; 54 header bytes in 54 consecutive cycles.
REQ-037 Same config, 4 beats with R0=0x10+k, G0=0x20+k, B0=0x30+k, R1=0x40+k, G1=0x50+k, B1=0x60+k (k=0..3) -> 24 pixel bytes, first six are 30 20 10 60 50 40; DONE pulses on byte 24 only; BUSY=0 two cycles later.
REQ-038 BYTE_READY toggled pseudo-randomly at 30% high -> byte sequence identical to REQ-037, and BYTE_OUT is never changed while stalled.
REQ-039 FIFO_DEPTH=4, BYTE_READY=0 during 6 consecutive HSYNC beats -> OVERFLOW=1, exactly 4 beats retained; after BYTE_READY=1, the 24 bytes of the first 4 beats are output.
REQ-040 HRESET asserted for 1 cycle at pixel byte 10 -> all outputs 0 the next cycle; a later VSYNC edge restarts cleanly with header byte 0x42.
REQ-041 Default 768x512 -> header file size bytes 36 00 12 00; DONE after 1179648 pixel bytes; VSYNC edges mid-frame are ignored.
